// File: rtl/maintenance_reminder.sv
// maintenance_reminder: per-channel usage tracker (h:m:s from a 100 Hz clock)
// with adjustable hour/minute thresholds and a standby maintenance warning.
module maintenance_reminder #(
  parameter int N_CH          = 2,
  parameter int SEL_W         = 1,
  parameter int HOUR_W        = 6,
  parameter int MAX_TH_HOUR   = 23,
  parameter int TICKS_PER_SEC = 100,
  parameter int DEF_HOUR      = 0,
  parameter int DEF_MIN       = 1
) (
  input  logic              clk_100Hz,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   run,
  input  logic              is_standby,
  input  logic              set_mode,
  input  logic              ch_sel_press_once,
  input  logic              unit_toggle_press_once,
  input  logic              inc_press_once,
  input  logic              dec_press_once,
  input  logic              clear_press_once,
  output logic [SEL_W-1:0]  sel_ch,
  output logic              adjust_unit,
  output logic [HOUR_W-1:0] sel_hour_th,
  output logic [5:0]        sel_min_th,
  output logic [HOUR_W-1:0] sel_used_hour,
  output logic [5:0]        sel_used_min,
  output logic [5:0]        sel_used_sec,
  output logic [N_CH-1:0]   warning,
  output logic              any_warning
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST     = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST    = {HOUR_W{1'b1}};
  localparam logic [HOUR_W-1:0] TH_HOUR_LAST = HOUR_W'(MAX_TH_HOUR);
  localparam logic [HOUR_W-1:0] TH_HOUR_RST  = HOUR_W'(DEF_HOUR);
  localparam logic [5:0]        TH_MIN_RST   = 6'(DEF_MIN);
  localparam logic [SEL_W-1:0]  SEL_LAST     = SEL_W'(N_CH - 1);

  typedef enum logic {ADJ_MIN = 1'b0, ADJ_HOUR = 1'b1} unit_state_t;

  unit_state_t       unit_state;
  unit_state_t       unit_state_next;
  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic              adj_en;
  logic              clear_en;
  logic [HOUR_W-1:0] used_hour [N_CH];
  logic [5:0]        used_min  [N_CH];
  logic [5:0]        used_sec  [N_CH];
  logic [HOUR_W-1:0] th_hour   [N_CH];
  logic [5:0]        th_min    [N_CH];
  logic [N_CH-1:0]   warning_next;

  assign tick     = (pre_cnt == PRE_LAST);
  assign adj_en   = is_standby && set_mode;
  assign clear_en = is_standby && clear_press_once;

  // Prescaler: one tick per TICKS_PER_SEC clock cycles.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Usage counters: clear of the selected channel beats a tick; saturate at max:59:59.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        used_hour[i] <= '0;
        used_min[i]  <= '0;
        used_sec[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clear_en && (sel_ch == SEL_W'(i))) begin
          used_hour[i] <= '0;
          used_min[i]  <= '0;
          used_sec[i]  <= '0;
        end else if (tick && run[i]) begin
          if (used_sec[i] != 6'd59) begin
            used_sec[i] <= used_sec[i] + 1'b1;
          end else if (used_min[i] != 6'd59) begin
            used_sec[i] <= '0;
            used_min[i] <= used_min[i] + 1'b1;
          end else if (used_hour[i] != HOUR_LAST) begin
            used_sec[i]  <= '0;
            used_min[i]  <= '0;
            used_hour[i] <= used_hour[i] + 1'b1;
          end
        end
      end
    end
  end

  // Threshold adjust on the channel selected before any same-cycle select press; inc beats dec.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        th_hour[i] <= TH_HOUR_RST;
        th_min[i]  <= TH_MIN_RST;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (adj_en && (sel_ch == SEL_W'(i))) begin
          if (inc_press_once) begin
            if (unit_state == ADJ_HOUR)
              th_hour[i] <= (th_hour[i] == TH_HOUR_LAST) ? '0 : th_hour[i] + 1'b1;
            else
              th_min[i] <= (th_min[i] == 6'd59) ? '0 : th_min[i] + 1'b1;
          end else if (dec_press_once) begin
            if (unit_state == ADJ_HOUR)
              th_hour[i] <= (th_hour[i] == '0) ? TH_HOUR_LAST : th_hour[i] - 1'b1;
            else
              th_min[i] <= (th_min[i] == 6'd0) ? 6'd59 : th_min[i] - 1'b1;
          end
        end
      end
    end
  end

  // Channel select advances modulo N_CH in any mode.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n)                 sel_ch <= '0;
    else if (ch_sel_press_once) sel_ch <= (sel_ch == SEL_LAST) ? '0 : sel_ch + 1'b1;
  end

  // Unit FSM state register.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) unit_state <= ADJ_MIN;
    else        unit_state <= unit_state_next;
  end

  // Unit FSM next state: toggle only while in set mode.
  always_comb begin
    unit_state_next = unit_state;
    if (set_mode && unit_toggle_press_once) begin
      case (unit_state)
        ADJ_MIN:  unit_state_next = ADJ_HOUR;
        ADJ_HOUR: unit_state_next = ADJ_MIN;
        default:  unit_state_next = ADJ_MIN;
      endcase
    end
  end

  // Unit FSM output decode.
  always_comb begin
    adjust_unit = (unit_state == ADJ_HOUR);
  end

  // Next warning: standby, not in set mode, not being cleared, and usage strictly above threshold.
  always_comb begin
    warning_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      warning_next[i] = is_standby && !set_mode &&
                        !(clear_en && (sel_ch == SEL_W'(i))) &&
                        ((used_hour[i] > th_hour[i]) ||
                         ((used_hour[i] == th_hour[i]) &&
                          ((used_min[i] > th_min[i]) ||
                           ((used_min[i] == th_min[i]) && (used_sec[i] != 6'd0)))));
    end
  end

  // Warning register and its registered OR.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      warning     <= '0;
      any_warning <= 1'b0;
    end else begin
      warning     <= warning_next;
      any_warning <= |warning_next;
    end
  end

  // Selected-channel view for the display.
  always_comb begin
    sel_hour_th   = '0;
    sel_min_th    = '0;
    sel_used_hour = '0;
    sel_used_min  = '0;
    sel_used_sec  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_ch == SEL_W'(i)) begin
        sel_hour_th   = th_hour[i];
        sel_min_th    = th_min[i];
        sel_used_hour = used_hour[i];
        sel_used_min  = used_min[i];
        sel_used_sec  = used_sec[i];
      end
    end
  end

endmodule

// File: tb/tb_maintenance_reminder.sv
// Testbench for maintenance_reminder: a fast-tick two-channel instance checked
// against a seconds-based reference model, a narrow-hour instance for
// saturation, and a default-rate instance for prescaler timing.
`timescale 1ns/1ps
module tb_maintenance_reminder;

  localparam int A_TICKS  = 1;
  localparam int A_MAX_TH = 23;
  localparam int A_MAXS   = 63 * 3600 + 59 * 60 + 59;
  localparam int B_MAXS   = 3 * 3600 + 59 * 60 + 59;

  int checks = 0;
  int errors = 0;

  logic clk_100Hz = 1'b0;
  always #5 clk_100Hz = ~clk_100Hz;

  logic tie0 = 1'b0;

  // instance A stimulus and outputs
  logic       rst_n = 1'b0;
  logic [1:0] run = '0;
  logic       is_standby = 1'b0, set_mode = 1'b0;
  logic       ch_sel = 1'b0, unit_tog = 1'b0, inc = 1'b0, dec = 1'b0, clr = 1'b0;
  logic [0:0] sel_ch;
  logic       adjust_unit;
  logic [5:0] sel_hour_th, sel_min_th, sel_used_hour, sel_used_min, sel_used_sec;
  logic [1:0] warning;
  logic       any_warning;

  // instance B (HOUR_W=2)
  logic       b_rst_n = 1'b0;
  logic [0:0] b_run = '0;
  logic       b_standby = 1'b0, b_set_mode = 1'b0, b_inc = 1'b0;
  logic [0:0] b_sel_ch;
  logic       b_adjust_unit;
  logic [1:0] b_sel_hour_th, b_sel_used_hour;
  logic [5:0] b_sel_min_th, b_sel_used_min, b_sel_used_sec;
  logic [0:0] b_warning;
  logic       b_any_warning;

  // instance C (default rate)
  logic       c_rst_n = 1'b0;
  logic [1:0] c_run = '0;
  logic [0:0] c_sel_ch;
  logic       c_adjust_unit;
  logic [5:0] c_sel_hour_th, c_sel_min_th, c_sel_used_hour, c_sel_used_min, c_sel_used_sec;
  logic [1:0] c_warning;
  logic       c_any_warning;

  maintenance_reminder #(.N_CH(2), .SEL_W(1), .HOUR_W(6), .MAX_TH_HOUR(23),
                         .TICKS_PER_SEC(1), .DEF_HOUR(0), .DEF_MIN(1)) dut (
    .clk_100Hz(clk_100Hz), .rst_n(rst_n), .run(run), .is_standby(is_standby),
    .set_mode(set_mode), .ch_sel_press_once(ch_sel), .unit_toggle_press_once(unit_tog),
    .inc_press_once(inc), .dec_press_once(dec), .clear_press_once(clr),
    .sel_ch(sel_ch), .adjust_unit(adjust_unit), .sel_hour_th(sel_hour_th),
    .sel_min_th(sel_min_th), .sel_used_hour(sel_used_hour), .sel_used_min(sel_used_min),
    .sel_used_sec(sel_used_sec), .warning(warning), .any_warning(any_warning));

  maintenance_reminder #(.N_CH(1), .SEL_W(1), .HOUR_W(2), .MAX_TH_HOUR(3),
                         .TICKS_PER_SEC(1), .DEF_HOUR(0), .DEF_MIN(1)) dut_sat (
    .clk_100Hz(clk_100Hz), .rst_n(b_rst_n), .run(b_run), .is_standby(b_standby),
    .set_mode(b_set_mode), .ch_sel_press_once(tie0), .unit_toggle_press_once(tie0),
    .inc_press_once(b_inc), .dec_press_once(tie0), .clear_press_once(tie0),
    .sel_ch(b_sel_ch), .adjust_unit(b_adjust_unit), .sel_hour_th(b_sel_hour_th),
    .sel_min_th(b_sel_min_th), .sel_used_hour(b_sel_used_hour), .sel_used_min(b_sel_used_min),
    .sel_used_sec(b_sel_used_sec), .warning(b_warning), .any_warning(b_any_warning));

  maintenance_reminder dut_rate (
    .clk_100Hz(clk_100Hz), .rst_n(c_rst_n), .run(c_run), .is_standby(tie0),
    .set_mode(tie0), .ch_sel_press_once(tie0), .unit_toggle_press_once(tie0),
    .inc_press_once(tie0), .dec_press_once(tie0), .clear_press_once(tie0),
    .sel_ch(c_sel_ch), .adjust_unit(c_adjust_unit), .sel_hour_th(c_sel_hour_th),
    .sel_min_th(c_sel_min_th), .sel_used_hour(c_sel_used_hour), .sel_used_min(c_sel_used_min),
    .sel_used_sec(c_sel_used_sec), .warning(c_warning), .any_warning(c_any_warning));

  // reference model of instance A: usage as total seconds, thresholds as h/m
  int         m_used [2];
  int         m_th_h [2];
  int         m_th_m [2];
  int         m_sel, m_unit, m_pre;
  logic [1:0] m_warn;
  logic       m_any;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_used[i] = 0; m_th_h[i] = 0; m_th_m[i] = 1;
    end
    m_sel = 0; m_unit = 0; m_pre = 0; m_warn = '0; m_any = 1'b0;
  endtask

  // one clock of instance A: model predicts from current inputs, then pulses drop
  task automatic cycle();
    int n_used [2];
    int n_th_h [2];
    int n_th_m [2];
    int n_sel, n_unit;
    logic [1:0] n_warn;
    logic tick_now, clr_i;
    tick_now = (m_pre == A_TICKS - 1);
    for (int i = 0; i < 2; i++) begin
      clr_i = clr && is_standby && (m_sel == i);
      n_warn[i] = is_standby && !set_mode && !clr_i &&
                  (m_used[i] > m_th_h[i] * 3600 + m_th_m[i] * 60);
      n_used[i] = m_used[i];
      if (clr_i) n_used[i] = 0;
      else if (tick_now && run[i] && m_used[i] < A_MAXS) n_used[i] = m_used[i] + 1;
      n_th_h[i] = m_th_h[i];
      n_th_m[i] = m_th_m[i];
    end
    if (is_standby && set_mode) begin
      if (inc) begin
        if (m_unit == 1) n_th_h[m_sel] = (m_th_h[m_sel] + 1) % (A_MAX_TH + 1);
        else             n_th_m[m_sel] = (m_th_m[m_sel] + 1) % 60;
      end else if (dec) begin
        if (m_unit == 1) n_th_h[m_sel] = (m_th_h[m_sel] + A_MAX_TH) % (A_MAX_TH + 1);
        else             n_th_m[m_sel] = (m_th_m[m_sel] + 59) % 60;
      end
    end
    n_unit = (set_mode && unit_tog) ? 1 - m_unit : m_unit;
    n_sel  = ch_sel ? (m_sel + 1) % 2 : m_sel;
    @(posedge clk_100Hz);
    for (int i = 0; i < 2; i++) begin
      m_used[i] = n_used[i]; m_th_h[i] = n_th_h[i]; m_th_m[i] = n_th_m[i];
    end
    m_sel = n_sel; m_unit = n_unit; m_warn = n_warn; m_any = |n_warn;
    m_pre = (m_pre + 1) % A_TICKS;
    @(negedge clk_100Hz);
    ch_sel = 1'b0; unit_tog = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_100Hz);
    model_reset();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({sel_hour_th, sel_min_th} !== {6'd0, 6'd1})
      $display("[TB] FAIL reset_threshold: got %0d:%0d expected 0:1", sel_hour_th, sel_min_th);
    checks++;
    if ({sel_ch, adjust_unit, warning, any_warning} !== 5'b0)
      $display("[TB] FAIL reset_ctrl: got sel=%0d unit=%0d warn=%b any=%b expected all 0",
               sel_ch, adjust_unit, warning, any_warning);
    if ({sel_ch, adjust_unit, warning, any_warning} !== 5'b0) errors++;
    if ({sel_hour_th, sel_min_th} !== {6'd0, 6'd1}) errors++;
    repeat (100) cycle();
    checks++;
    if ({sel_used_hour, sel_used_min, sel_used_sec} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL idle_usage: got %0d:%0d:%0d expected 0:0:0",
               sel_used_hour, sel_used_min, sel_used_sec);
    end
  endtask

  task automatic test_accrual();
    int guard = 0;
    is_standby = 1'b1; set_mode = 1'b0; run = 2'b01;
    while (m_used[0] < 60 && guard < 200) begin cycle(); guard++; end
    checks++;
    if ({sel_used_hour, sel_used_min, sel_used_sec} !== {6'd0, 6'd1, 6'd0} || warning !== 2'b00) begin
      errors++;
      $display("[TB] FAIL accrual_0_01_00: got %0d:%0d:%0d warn=%b expected 0:1:0 warn=00",
               sel_used_hour, sel_used_min, sel_used_sec, warning);
    end
    cycle();
    checks++;
    if (sel_used_sec !== 6'd1 || warning !== 2'b00) begin
      errors++;
      $display("[TB] FAIL accrual_0_01_01: got sec=%0d warn=%b expected sec=1 warn=00",
               sel_used_sec, warning);
    end
    cycle();
    checks++;
    if (warning !== 2'b01 || any_warning !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accrual_warn: got warn=%b any=%b expected 01 1", warning, any_warning);
    end
    run = 2'b00;
    cycle();
    ch_sel = 1'b1;
    cycle();
    checks++;
    if (sel_ch !== 1'b1 || {sel_used_hour, sel_used_min, sel_used_sec} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL ch1_idle: got sel=%0d usage=%0d:%0d:%0d expected sel=1 usage 0:0:0",
               sel_ch, sel_used_hour, sel_used_min, sel_used_sec);
    end
    ch_sel = 1'b1;
    cycle();
  endtask

  task automatic test_adjust();
    is_standby = 1'b1; set_mode = 1'b1;
    cycle();
    checks++;
    if (warning !== 2'b00) begin
      errors++;
      $display("[TB] FAIL setmode_suppress: got %b expected 00", warning);
    end
    ch_sel = 1'b1; cycle();
    unit_tog = 1'b1; cycle();
    checks++;
    if (sel_ch !== 1'b1 || adjust_unit !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sel_unit: got sel=%0d unit=%0d expected 1 1", sel_ch, adjust_unit);
    end
    dec = 1'b1; cycle();
    checks++;
    if ({sel_hour_th, sel_min_th} !== {6'd23, 6'd1}) begin
      errors++;
      $display("[TB] FAIL hour_dec_wrap: got %0d:%0d expected 23:1", sel_hour_th, sel_min_th);
    end
    inc = 1'b1; cycle();
    checks++;
    if ({sel_hour_th, sel_min_th} !== {6'd0, 6'd1}) begin
      errors++;
      $display("[TB] FAIL hour_inc_wrap: got %0d:%0d expected 0:1", sel_hour_th, sel_min_th);
    end
    unit_tog = 1'b1; cycle();
    dec = 1'b1; cycle();
    dec = 1'b1; cycle();
    checks++;
    if (sel_min_th !== 6'd59 || adjust_unit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL min_dec_wrap: got min=%0d unit=%0d expected 59 0", sel_min_th, adjust_unit);
    end
    inc = 1'b1; cycle();
    checks++;
    if ({sel_hour_th, sel_min_th} !== {6'd0, 6'd0}) begin
      errors++;
      $display("[TB] FAIL min_inc_wrap: got %0d:%0d expected 0:0", sel_hour_th, sel_min_th);
    end
    ch_sel = 1'b1; cycle();
    checks++;
    if (sel_ch !== 1'b0 || {sel_hour_th, sel_min_th} !== {6'd0, 6'd1}) begin
      errors++;
      $display("[TB] FAIL ch0_untouched: got sel=%0d th=%0d:%0d expected 0 0:1",
               sel_ch, sel_hour_th, sel_min_th);
    end
    inc = 1'b1; dec = 1'b1; cycle();
    checks++;
    if (sel_min_th !== 6'd2) begin
      errors++;
      $display("[TB] FAIL inc_dec_priority: got %0d expected 2", sel_min_th);
    end
    dec = 1'b1; cycle();
  endtask

  task automatic test_suppression();
    set_mode = 1'b0; is_standby = 1'b1;
    cycle();
    checks++;
    if (warning !== 2'b01) begin
      errors++;
      $display("[TB] FAIL warn_restore: got %b expected 01", warning);
    end
    set_mode = 1'b1; cycle();
    checks++;
    if (warning !== 2'b00 || any_warning !== 1'b0) begin
      errors++;
      $display("[TB] FAIL setmode_drop: got %b any=%b expected 00 0", warning, any_warning);
    end
    set_mode = 1'b0; cycle();
    is_standby = 1'b0; clr = 1'b1; cycle();
    checks++;
    if (warning !== 2'b00 || {sel_used_min, sel_used_sec} !== {6'd1, 6'd2}) begin
      errors++;
      $display("[TB] FAIL run_mode: got warn=%b usage=%0d:%0d expected 00 1:2",
               warning, sel_used_min, sel_used_sec);
    end
  endtask

  task automatic test_clear_vs_tick();
    is_standby = 1'b1; set_mode = 1'b0; run = 2'b11;
    cycle();
    clr = 1'b1; cycle();
    checks++;
    if ({sel_used_hour, sel_used_min, sel_used_sec} !== 18'd0 || warning[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_wins: got %0d:%0d:%0d warn0=%b expected 0:0:0 0",
               sel_used_hour, sel_used_min, sel_used_sec, warning[0]);
    end
    run = 2'b00;
    ch_sel = 1'b1; cycle();
    checks++;
    if (sel_used_sec !== 6'd2 || m_used[1] != 2) begin
      errors++;
      $display("[TB] FAIL unselected_runs: got sec=%0d expected 2", sel_used_sec);
    end
    ch_sel = 1'b1; cycle();
  endtask

  task automatic test_random();
    int s;
    for (int n = 0; n < 400; n++) begin
      run        = 2'($urandom);
      is_standby = ($urandom_range(0, 3) != 0);
      set_mode   = ($urandom_range(0, 3) == 0);
      ch_sel     = ($urandom_range(0, 5) == 0);
      unit_tog   = ($urandom_range(0, 5) == 0);
      inc        = ($urandom_range(0, 3) == 0);
      dec        = ($urandom_range(0, 3) == 0);
      clr        = ($urandom_range(0, 15) == 0);
      cycle();
      s = m_used[m_sel];
      checks++;
      if (sel_ch !== 1'(m_sel) || adjust_unit !== 1'(m_unit)) begin
        errors++;
        $display("[TB] FAIL rnd_ctrl: got sel=%0d unit=%0d expected %0d %0d",
                 sel_ch, adjust_unit, m_sel, m_unit);
      end
      checks++;
      if ({sel_hour_th, sel_min_th} !== {6'(m_th_h[m_sel]), 6'(m_th_m[m_sel])}) begin
        errors++;
        $display("[TB] FAIL rnd_threshold: got %0d:%0d expected %0d:%0d",
                 sel_hour_th, sel_min_th, m_th_h[m_sel], m_th_m[m_sel]);
      end
      checks++;
      if ({sel_used_hour, sel_used_min, sel_used_sec} !== {6'(s / 3600), 6'((s / 60) % 60), 6'(s % 60)}) begin
        errors++;
        $display("[TB] FAIL rnd_usage: got %0d:%0d:%0d expected %0d seconds",
                 sel_used_hour, sel_used_min, sel_used_sec, s);
      end
      checks++;
      if (warning !== m_warn || any_warning !== m_any) begin
        errors++;
        $display("[TB] FAIL rnd_warning: got %b any=%b expected %b %b",
                 warning, any_warning, m_warn, m_any);
      end
    end
  endtask

  task automatic test_saturation();
    int e;
    @(negedge clk_100Hz); b_rst_n = 1'b1;
    b_standby = 1'b1; b_set_mode = 1'b1; b_inc = 1'b1;
    @(negedge clk_100Hz); b_inc = 1'b0;
    checks++;
    if (b_sel_min_th !== 6'd2) begin
      errors++;
      $display("[TB] FAIL sat_th_inc: got %0d expected 2", b_sel_min_th);
    end
    b_run = 1'b1;
    for (int n = 1; n <= B_MAXS + 6; n++) begin
      @(negedge clk_100Hz);
      e = (n < B_MAXS) ? n : B_MAXS;
      checks++;
      if ({b_sel_used_hour, b_sel_used_min, b_sel_used_sec} !== {2'(e / 3600), 6'((e / 60) % 60), 6'(e % 60)}) begin
        errors++;
        $display("[TB] FAIL sat_usage: cycle %0d got %0d:%0d:%0d expected %0d seconds",
                 n, b_sel_used_hour, b_sel_used_min, b_sel_used_sec, e);
      end
    end
    b_run = 1'b0; b_rst_n = 1'b0;
    @(negedge clk_100Hz); b_rst_n = 1'b1;
    b_inc = 1'b1;
    @(negedge clk_100Hz); b_inc = 1'b0; b_run = 1'b1;
    repeat (37) @(negedge clk_100Hz);
    checks++;
    if ({b_sel_used_min, b_sel_used_sec} !== {6'd0, 6'd37} || b_sel_min_th !== 6'd2) begin
      errors++;
      $display("[TB] FAIL pre_reset: got %0d:%0d th_min=%0d expected 0:37 2",
               b_sel_used_min, b_sel_used_sec, b_sel_min_th);
    end
    #2 b_rst_n = 1'b0;
    #1;
    checks++;
    if ({b_sel_used_hour, b_sel_used_min, b_sel_used_sec} !== 14'd0 ||
        {b_sel_hour_th, b_sel_min_th} !== {2'd0, 6'd1}) begin
      errors++;
      $display("[TB] FAIL async_reset: got usage %0d:%0d:%0d th %0d:%0d expected 0:0:0 0:1",
               b_sel_used_hour, b_sel_used_min, b_sel_used_sec, b_sel_hour_th, b_sel_min_th);
    end
  endtask

  task automatic test_first_tick();
    int k;
    c_run = 2'b01;
    @(negedge clk_100Hz); c_rst_n = 1'b1;
    k = 0;
    while (k < 300 && c_sel_used_sec == 6'd0) begin @(negedge clk_100Hz); k++; end
    checks++;
    if (k != 100) begin
      errors++;
      $display("[TB] FAIL first_tick: got %0d cycles expected 100", k);
    end
    repeat (50) @(negedge clk_100Hz);
    #2 c_rst_n = 1'b0;
    #1;
    checks++;
    if (c_sel_used_sec !== 6'd0) begin
      errors++;
      $display("[TB] FAIL rate_reset: got sec=%0d expected 0", c_sel_used_sec);
    end
    @(negedge clk_100Hz); c_rst_n = 1'b1;
    k = 0;
    while (k < 300 && c_sel_used_sec == 6'd0) begin @(negedge clk_100Hz); k++; end
    checks++;
    if (k != 100) begin
      errors++;
      $display("[TB] FAIL prescaler_cleared: got %0d cycles expected 100", k);
    end
  endtask

  initial begin
    $display("[TB] maintenance_reminder bench start");
    test_reset();
    test_accrual();
    test_adjust();
    test_suppression();
    test_clear_vs_tick();
    test_random();
    test_first_tick();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
